// File: rtl/fetch_stage_pkg.sv
// Shared constants for the instruction fetch stage.
//   INST_WIDTH   : instruction word width
//   PC_STEP      : byte increment between sequential fetches
//   PC_ALIGN_LSB : number of low PC bits forced to zero (word alignment)
package fetch_stage_pkg;

    localparam int INST_WIDTH   = 32;
    localparam int PC_STEP      = 4;
    localparam int PC_ALIGN_LSB = 2;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory request/response channel and
// the decode-side valid/ready channel.
//   master : the fetch stage (drives requests, presents instructions)
//   slave  : the environment (instruction memory + decode)
interface fetch_stage_if
    import fetch_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
);
    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic                  imem_rsp_valid;
    logic [INST_WIDTH-1:0] imem_rsp_data;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [INST_WIDTH-1:0] inst;
    logic [ADDR_WIDTH-1:0] inst_pc;

    modport master (
        output imem_req_valid, imem_addr, inst_valid, inst, inst_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr, inst_valid, inst, inst_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush, used for the PC tag queue and the
// instruction buffer.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush_i    : empties the FIFO; overrides push_i/pop_i in the same cycle
//   push_i     : write data_i (ignored when full)
//   pop_i      : advance head (ignored when empty)
//   data_o     : head entry (undefined when empty)
//   count_o    : number of stored entries
//   empty_o    : count_o == 0
//   full_o     : count_o == DEPTH
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !flush_i && !full_o;
    assign do_pop  = pop_i  && !flush_i && !empty_o;

    // NOTE: storage is deliberately not reset; count_q alone says which
    // entries are meaningful, and leaving the array out of reset keeps it a
    // plain register file / RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap on their own.
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage. Owns the PC, issues in-order word requests to
// instruction memory, buffers returned words with their PC and hands them to
// decode over valid/ready. A branch redirect flushes buffered words and
// marks all in-flight fetches for discard.
//   clk, rst_n       : clock, asynchronous active-low reset
//   branch_valid_i   : one-cycle redirect pulse from execute
//   branch_target_i  : redirect address (low two bits ignored)
//   bus_io (master)  : imem request/response and decode handshake
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  branch_valid_i,
    input  logic [ADDR_WIDTH-1:0] branch_target_i,
    fetch_stage_if.master         bus_io
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int BW = ADDR_WIDTH + INST_WIDTH;

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [CW-1:0]         outstanding_q, outstanding_d;
    logic [CW-1:0]         drop_q, drop_d;
    logic                  started_q;

    logic [CW-1:0]         tag_count, buf_count;
    logic                  tag_empty, tag_full, buf_empty, buf_full;
    logic [ADDR_WIDTH-1:0] tag_head;
    logic [BW-1:0]         buf_head;
    logic [CW:0]           in_use;
    logic                  issue, rsp_fire, rsp_drop, rsp_keep, inst_pop;
    logic                  unused_tag_count;

    assign unused_tag_count = ^tag_count;

    // Credit covers words in flight plus words already buffered, so a
    // response always has a buffer slot waiting for it. started_q holds the
    // request off until the first clock after reset release.
    assign in_use = {1'b0, outstanding_q} + {1'b0, buf_count};
    assign bus_io.imem_req_valid = started_q && !branch_valid_i
                                   && (in_use < (CW+1)'(DEPTH));
    assign bus_io.imem_addr      = pc_q;

    assign issue    = bus_io.imem_req_valid && bus_io.imem_req_ready;
    assign rsp_fire = bus_io.imem_rsp_valid && (outstanding_q != '0);
    assign rsp_drop = rsp_fire && (drop_q != '0);
    // A response landing on the redirect cycle belongs to the old path.
    assign rsp_keep = rsp_fire && (drop_q == '0) && !branch_valid_i;
    assign inst_pop = bus_io.inst_valid && bus_io.inst_ready;

    fetch_fifo #(.WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_tag_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (branch_valid_i),
        .push_i  (issue),
        .data_i  (pc_q),
        .pop_i   (rsp_keep),
        .data_o  (tag_head),
        .count_o (tag_count),
        .empty_o (tag_empty),
        .full_o  (tag_full)
    );

    fetch_fifo #(.WIDTH(BW), .DEPTH(DEPTH)) u_inst_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (branch_valid_i),
        .push_i  (rsp_keep),
        .data_i  ({tag_head, bus_io.imem_rsp_data}),
        .pop_i   (inst_pop),
        .data_o  (buf_head),
        .count_o (buf_count),
        .empty_o (buf_empty),
        .full_o  (buf_full)
    );

    // Outputs read zero whenever nothing is buffered, including during reset.
    assign bus_io.inst_valid = !buf_empty;
    assign bus_io.inst       = buf_empty ? '0 : buf_head[INST_WIDTH-1:0];
    assign bus_io.inst_pc    = buf_empty ? '0 : buf_head[BW-1:INST_WIDTH];

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        pc_d          = pc_q;
        outstanding_d = outstanding_q + CW'(issue) - CW'(rsp_fire);
        drop_d        = drop_q;
        if (branch_valid_i) begin
            pc_d   = {branch_target_i[ADDR_WIDTH-1:PC_ALIGN_LSB], {PC_ALIGN_LSB{1'b0}}};
            // Everything still in flight after this edge is old-path.
            drop_d = outstanding_q - CW'(rsp_fire);
        end else begin
            if (issue)    pc_d   = pc_q + ADDR_WIDTH'(PC_STEP);
            if (rsp_drop) drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            started_q     <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            started_q     <= 1'b1;
        end
    end

    ap_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
        bus_io.imem_rsp_valid |-> (outstanding_q != '0));
    ap_tag_space: assert property (@(posedge clk) disable iff (!rst_n)
        issue |-> !tag_full);
    ap_tag_present: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_keep |-> !tag_empty);
    ap_buf_space: assert property (@(posedge clk) disable iff (!rst_n)
        (rsp_keep && !inst_pop) |-> !buf_full);
endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    localparam int          AW       = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } imem_req_t;

    typedef struct {
        logic [31:0] pc;
        int          rsp_cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        branch_valid;
    logic [31:0] branch_target;

    fetch_stage_if #(.ADDR_WIDTH(AW)) bus ();

    fetch_stage #(.ADDR_WIDTH(AW), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .branch_valid_i  (branch_valid),
        .branch_target_i (branch_target),
        .bus_io          (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    imem_req_t   imem_q[$];
    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          last_due = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    logic [31:0] exp_addr = RESET_PC;
    bit          after_branch = 0;
    bit          stall_prev = 0;
    logic [31:0] prev_inst, prev_pc;
    int          issued_cnt = 0;
    int          delivered_cnt = 0;
    bit          cyc_issued, cyc_popped;
    logic [31:0] last_issue_addr, last_pop_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        imem_q.delete();
        exp_q.delete();
        epoch++;
        last_due     = cyc;
        exp_addr     = RESET_PC;
        after_branch = 0;
        stall_prev   = 0;
    endtask

    // One clock: drive the imem response, sample mid-cycle, check against
    // the model, then advance the model across the rising edge.
    task automatic cycle();
        bit issue, pop, rsp, br;
        int buffered, lat, due;
        if (imem_q.size() > 0 && imem_q[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(imem_q[0].addr);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
        end
        @(negedge clk);
        issue = bus.imem_req_valid && bus.imem_req_ready;
        pop   = bus.inst_valid && bus.inst_ready;
        rsp   = bus.imem_rsp_valid;
        br    = branch_valid;

        if (after_branch) check("inst_valid_after_redirect", bus.inst_valid, 1'b0);
        else if (stall_prev) begin
            check("stall_valid", bus.inst_valid, 1'b1);
            check("stall_inst", bus.inst, prev_inst);
            check("stall_pc", bus.inst_pc, prev_pc);
        end
        if (br) check("no_req_on_redirect", bus.imem_req_valid, 1'b0);
        if (issue) begin
            buffered = 0;
            foreach (exp_q[i]) if (exp_q[i].rsp_cyc >= 0) buffered++;
            check("credit", ((imem_q.size() + buffered) < DEPTH), 1'b1);
            check("req_addr", bus.imem_addr, exp_addr);
        end
        if (bus.inst_valid) begin
            if (exp_q.size() == 0) check("spurious_inst_valid", bus.inst_valid, 1'b0);
            else begin
                check("inst_pc", bus.inst_pc, exp_q[0].pc);
                check("inst_data", bus.inst, mem_word(exp_q[0].pc));
                check("no_bypass", (exp_q[0].rsp_cyc >= 0 && exp_q[0].rsp_cyc < cyc), 1'b1);
            end
        end

        if (rsp) begin
            if (imem_q[0].epoch == epoch && !br) begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    if (exp_q[i].rsp_cyc < 0) begin
                        exp_q[i].rsp_cyc = cyc;
                        break;
                    end
                end
            end
            void'(imem_q.pop_front());
        end
        cyc_popped = pop && !br;
        if (cyc_popped) begin
            last_pop_pc = bus.inst_pc;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            delivered_cnt++;
        end
        if (br) begin
            epoch++;
            exp_q.delete();
            exp_addr = branch_target & ~32'h3;
        end
        cyc_issued = issue && !br;
        if (issue) begin
            lat = $urandom_range(lat_max, lat_min);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            imem_q.push_back('{addr: bus.imem_addr, epoch: (br ? -1 : epoch), due: due});
            if (!br) begin
                exp_q.push_back('{pc: bus.imem_addr, rsp_cyc: -1});
                exp_addr = exp_addr + 32'd4;
                issued_cnt++;
                last_issue_addr = bus.imem_addr;
            end
        end
        after_branch = br;
        stall_prev   = bus.inst_valid && !bus.inst_ready && !br;
        prev_inst    = bus.inst;
        prev_pc      = bus.inst_pc;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic wait_issue(input int budget, input string tag);
        bit got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            cycle();
            got = cyc_issued;
        end
        check(tag, got, 1'b1);
    endtask

    task automatic wait_pop(input int budget, input string tag);
        bit got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            cycle();
            got = cyc_popped;
        end
        check(tag, got, 1'b1);
    endtask

    task automatic release_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int d0, i0, live, found;
        rst_n              = 1'b0;
        branch_valid       = 1'b0;
        branch_target      = '0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.inst_ready     = 1'b0;
        #1;
        check("reset_req_valid", bus.imem_req_valid, 1'b0);
        check("reset_inst_valid", bus.inst_valid, 1'b0);
        check("reset_inst", bus.inst, 32'h0);
        check("reset_inst_pc", bus.inst_pc, 32'h0);
        check("reset_addr", bus.imem_addr, RESET_PC);
        release_reset();

        // 1: sequential fetch, 1-cycle imem, no stalls.
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = 1'b1;
        lat_min = 1; lat_max = 1;
        wait_issue(5, "first_req_seen");
        check("first_req_addr", last_issue_addr, RESET_PC);
        run(10);
        d0 = delivered_cnt;
        run(20);
        check("steady_throughput", delivered_cnt - d0, 20);

        // 2: decode stall fills the buffer, then release.
        bus.inst_ready = 1'b0;
        i0 = issued_cnt;
        run(10);
        check("stall_issue_bound", ((issued_cnt - i0) <= DEPTH), 1'b1);
        check("stall_req_valid_low", bus.imem_req_valid, 1'b0);
        check("stall_buffer_full", exp_q.size(), DEPTH);
        bus.inst_ready = 1'b1;
        run(10);

        // 3: redirect with two fetches in flight.
        lat_min = 4; lat_max = 4;
        live = 0;
        for (int i = 0; i < 20 && live < 2; i++) begin
            cycle();
            live = 0;
            foreach (exp_q[k]) if (exp_q[k].rsp_cyc < 0) live++;
        end
        check("two_in_flight", (live >= 2), 1'b1);
        branch_valid = 1'b1; branch_target = 32'h103;
        cycle();
        branch_valid = 1'b0;
        wait_issue(5, "redirect_req_seen");
        check("redirect_req_addr", last_issue_addr, 32'h100);
        wait_pop(20, "redirect_inst_seen");
        check("redirect_first_pc", last_pop_pc, 32'h100);

        // 4: redirect on the same cycle as a response and a decode pop.
        lat_min = 1; lat_max = 1;
        run(10);
        found = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            if (imem_q.size() > 0 && imem_q[0].due <= cyc && bus.inst_valid) found = 1;
            else cycle();
        end
        check("collision_setup", found, 1);
        branch_valid = 1'b1; branch_target = 32'h200;
        cycle();
        branch_valid = 1'b0;
        wait_pop(20, "collision_inst_seen");
        check("collision_first_pc", last_pop_pc, 32'h200);

        // 5: PC wrap, then randomized latency, backpressure and redirects.
        branch_valid = 1'b1; branch_target = 32'hFFFF_FFFD;
        cycle();
        branch_valid = 1'b0;
        wait_issue(5, "wrap_req_seen");
        check("wrap_req_addr", last_issue_addr, 32'hFFFF_FFFC);
        wait_issue(5, "wrap_next_seen");
        check("wrap_next_addr", last_issue_addr, 32'h0000_0000);
        lat_min = 1; lat_max = 5;
        for (int i = 0; i < 1500; i++) begin
            bus.imem_req_ready = ($urandom_range(4, 0) != 0);
            bus.inst_ready     = ($urandom_range(3, 0) != 0);
            branch_valid       = ($urandom_range(99, 0) < 4);
            branch_target      = $urandom;
            cycle();
        end
        branch_valid       = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = 1'b1;
        run(20);

        // 6: asynchronous reset in the middle of a burst.
        lat_min = 2; lat_max = 2;
        run(10);
        #2;
        rst_n = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        #1;
        check("midrst_req_valid", bus.imem_req_valid, 1'b0);
        check("midrst_inst_valid", bus.inst_valid, 1'b0);
        check("midrst_inst", bus.inst, 32'h0);
        check("midrst_inst_pc", bus.inst_pc, 32'h0);
        check("midrst_addr", bus.imem_addr, RESET_PC);
        release_reset();
        wait_issue(5, "restart_req_seen");
        check("restart_req_addr", last_issue_addr, RESET_PC);
        wait_pop(10, "restart_inst_seen");
        check("restart_first_pc", last_pop_pc, RESET_PC);
        run(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
